// File: rtl/ram1r_stream_reader_pkg.sv
// Shared types for the RAM read-stream engine: FSM state encoding and the
// output-buffer sizing used by both the top and the 2-entry FIFO.
package ram1r_stream_reader_pkg;

    // Command sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } ramrd_state_t;

    // Output buffer depth; also the number of read credits
    localparam int RAMRD_FIFO_DEPTH = 2;

    // Occupancy of the output buffer (0..2)
    typedef logic [1:0] ramrd_occ_t;

endpackage : ram1r_stream_reader_pkg

// File: rtl/ram1r_stream_reader_if.sv
// Bundle of command, status, RAM read-port and output-stream signals.
// master: command source / RAM / consumer side; slave: the read engine.
interface ram1r_stream_reader_if #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 68
);
    localparam int AW = $clog2(DEPTH);

    logic             Start;
    logic [AW-1:0]    StartAdr;
    logic [AW:0]      Len;
    logic             Busy;
    logic             Done;
    logic             Err;
    logic             ce1;
    logic [AW-1:0]    ra1;
    logic [WIDTH-1:0] rd1;
    logic             OutValid;
    logic             OutReady;
    logic [WIDTH-1:0] OutData;

    modport master (
        output Start, StartAdr, Len, rd1, OutReady,
        input  Busy, Done, Err, ce1, ra1, OutValid, OutData
    );

    modport slave (
        input  Start, StartAdr, Len, rd1, OutReady,
        output Busy, Done, Err, ce1, ra1, OutValid, OutData
    );

endinterface : ram1r_stream_reader_if

// File: rtl/ram1r_stream_reader_fifo2.sv
// Two-entry WIDTH-bit FIFO holding read words the consumer has not taken yet.
// Storage is cleared on reset so the head reads as zero out of reset.
module ramrd_fifo2
    import ram1r_stream_reader_pkg::*;
#(
    parameter int WIDTH = 68
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output ramrd_occ_t       occ_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    ramrd_occ_t       occ_q;
    ramrd_occ_t       occ_d;

    // Occupancy follows push/pop; simultaneous push and pop leaves it unchanged
    always_comb begin
        occ_d = occ_q;
        if (push_i && !pop_i) begin
            occ_d = occ_q + 2'd1;
        end else if (pop_i && !push_i) begin
            occ_d = occ_q - 2'd1;
        end
    end

    // Storage, pointers and occupancy registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q <= occ_d;
        end
    end

    assign dout_o = mem_q[rd_ptr_q];
    assign occ_o  = occ_q;

endmodule : ramrd_fifo2

// File: rtl/ram1r_stream_reader.sv
// Block-read engine for the read port of a 1R/1W SRAM. A command (start
// address, length) is turned into back-to-back ce1/ra1 accesses; returning
// words are streamed out in order on a valid/ready interface.
//
// Build option: define RAMRD_WRAP_EN to let the address counter wrap from
// DEPTH-1 to 0; otherwise commands running past the end of the RAM are
// rejected with Err.
//
// Pipeline: the issue decision in cycle t is registered into ce1/ra1 (cycle
// t+1); the RAM returns the word on rd1 in cycle t+2. A word on rd1 is shown
// directly on OutData when the buffer is empty, otherwise it is queued.
// Credits cover buffered words, the word on rd1 and the access on ce1, so at
// most two words are ever owed to the consumer.
module ram1r_stream_reader
    import ram1r_stream_reader_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 68
) (
    input  logic                 clk,
    input  logic                 reset,
    ram1r_stream_reader_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    ramrd_state_t     state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [LW-1:0]    rem_q, rem_d;
    logic             ce1_q, ce1_d;
    logic [AW-1:0]    ra1_q, ra1_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             rdv_q;
    logic             busy_q;

    ramrd_occ_t       occ;
    logic [WIDTH-1:0] head;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_empty;
    logic             out_valid;
    logic             pop;
    logic [2:0]       pending;
    logic [2:0]       after_pop;
    logic             credit_ok;
    logic             drained;
    logic             cmd_bad;
    logic             busy;

`ifdef RAMRD_WRAP_EN
    assign cmd_bad = (bus.Len > DEPTH_L);
`else
    logic [AW+1:0] end_adr;
    assign end_adr = {2'b00, bus.StartAdr} + {1'b0, bus.Len};
    assign cmd_bad = (end_adr > {1'b0, DEPTH_L});
`endif

    // Output stream: a word on rd1 bypasses the empty buffer
    assign fifo_empty = (occ == 2'd0);
    assign out_valid  = !fifo_empty || rdv_q;
    assign pop        = out_valid && bus.OutReady;
    assign fifo_pop   = pop && !fifo_empty;
    assign fifo_push  = rdv_q && !(pop && fifo_empty);

    // Credit accounting: words owed after this cycle's pop
    assign pending   = {1'b0, occ} + {2'b00, ce1_q} + {2'b00, rdv_q};
    assign after_pop = pending - {2'b00, pop};
    assign credit_ok = (after_pop < 3'(RAMRD_FIFO_DEPTH));
    assign drained   = (after_pop == 3'd0);

    ramrd_fifo2 #(
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push_i (fifo_push),
        .pop_i  (fifo_pop),
        .din_i  (bus.rd1),
        .dout_o (head),
        .occ_o  (occ)
    );

    // Next-state, issue and completion decisions
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        ce1_d   = 1'b0;
        ra1_d   = ra1_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.Start && !busy_q) begin
                    if (bus.Len == '0) begin
                        done_d = 1'b1;
                    end else if (cmd_bad) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        ce1_d   = 1'b1;
                        ra1_d   = bus.StartAdr;
                        addr_d  = bus.StartAdr + AW'(1);
                        rem_d   = bus.Len - LW'(1);
                        state_d = (bus.Len == LW'(1)) ? DRAIN : ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (credit_ok && (rem_q != '0)) begin
                    ce1_d  = 1'b1;
                    ra1_d  = addr_q;
                    addr_d = addr_q + AW'(1);
                    rem_d  = rem_q - LW'(1);
                    if (rem_q == LW'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drained) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control registers; reset abandons any command and in-flight read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            ce1_q   <= 1'b0;
            ra1_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdv_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            ce1_q   <= ce1_d;
            ra1_q   <= ra1_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdv_q   <= ce1_q;
            busy_q  <= (state_q != IDLE);
        end
    end

    // Busy covers the whole command including the Done cycle
    assign busy = (state_q != IDLE) || busy_q;

    assign bus.Busy     = busy;
    assign bus.Done     = done_q;
    assign bus.Err      = err_q;
    assign bus.ce1      = ce1_q;
    assign bus.ra1      = ra1_q;
    assign bus.OutValid = out_valid;
    assign bus.OutData  = (fifo_empty && rdv_q) ? bus.rd1 : head;

endmodule : ram1r_stream_reader

// File: tb/tb_ram1r_stream_reader.sv
// Bench for ram1r_stream_reader with DEPTH=16: behavioural RAM, scoreboard
// queue filled when commands are driven and drained by the stream monitor.
module tb_ram1r_stream_reader;

    localparam int DEPTH = 16;
    localparam int WIDTH = 68;
    localparam int AW    = 4;
    localparam int LW    = 5;

    typedef logic [WIDTH-1:0] w_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    ram1r_stream_reader_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    ram1r_stream_reader #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    w_t mem [DEPTH];
    w_t rd1_q = '0;

    always @(posedge clk) begin
        if (bus.ce1) rd1_q <= mem[bus.ra1];
    end
    assign bus.rd1 = rd1_q;

    w_t exp_q [$];
    int n_tests  = 0;
    int n_fail   = 0;
    int ce1_cnt  = 0;
    int word_cnt = 0;
    logic stall_prev = 1'b0;
    w_t   data_prev  = '0;

    task automatic check_val(input string tag, input w_t act, input w_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Stream monitor: scoreboard compare, hold-under-stall check, ce1 count
    always @(negedge clk) begin
        if (reset) begin
            stall_prev <= 1'b0;
        end else begin
            if (bus.ce1) ce1_cnt <= ce1_cnt + 1;
            if (stall_prev) begin
                check_val("hold_valid", w_t'(bus.OutValid), w_t'(1));
                check_val("hold_data", bus.OutData, data_prev);
            end
            if (bus.OutValid && bus.OutReady) begin
                word_cnt <= word_cnt + 1;
                check_val("sb_nonempty", w_t'(exp_q.size() > 0), w_t'(1));
                if (exp_q.size() > 0) check_val("word", bus.OutData, exp_q.pop_front());
            end
            stall_prev <= bus.OutValid && !bus.OutReady;
            data_prev  <= bus.OutData;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmd(input int adr, input int len, input bit push_exp);
        bus.Start    = 1'b1;
        bus.StartAdr = AW'(adr);
        bus.Len      = LW'(len);
        if (push_exp) begin
            for (int i = 0; i < len; i++) exp_q.push_back(mem[(adr + i) % DEPTH]);
        end
    endtask

    task automatic wait_done(input string tag, input int bound, output logic err);
        bit seen;
        seen = 1'b0;
        err  = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (bus.Done) begin
                seen = 1'b1;
                err  = bus.Err;
            end
        end
        check_val(tag, w_t'(seen), w_t'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic e;
        int   c0, w0, n2;
        for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom, 4'(i)};
        bus.Start    = 1'b0;
        bus.StartAdr = '0;
        bus.Len      = '0;
        bus.OutReady = 1'b1;

        // Reset values
        @(negedge clk);
        check_val("rst_busy", w_t'(bus.Busy), w_t'(0));
        check_val("rst_done", w_t'(bus.Done), w_t'(0));
        check_val("rst_err", w_t'(bus.Err), w_t'(0));
        check_val("rst_ce1", w_t'(bus.ce1), w_t'(0));
        check_val("rst_ra1", w_t'(bus.ra1), w_t'(0));
        check_val("rst_valid", w_t'(bus.OutValid), w_t'(0));
        check_val("rst_data", bus.OutData, w_t'(0));
        @(posedge clk);
        #1 reset = 1'b0;
        tick();

        // Basic block read, consumer always ready
        c0 = ce1_cnt;
        start_cmd(3, 4, 1'b1);
        for (int c = 0; c <= 7; c++) begin
            @(negedge clk);
            if (c >= 1 && c <= 4) check_val("t1_ra1", w_t'(bus.ra1), w_t'(3 + c - 1));
            check_val("t1_ce1", w_t'(bus.ce1), w_t'(c >= 1 && c <= 4));
            check_val("t1_valid", w_t'(bus.OutValid), w_t'(c >= 2 && c <= 5));
            check_val("t1_done", w_t'(bus.Done), w_t'(c == 6));
            check_val("t1_err", w_t'(bus.Err), w_t'(0));
            check_val("t1_busy", w_t'(bus.Busy), w_t'(c >= 1 && c <= 6));
            tick();
            if (c == 0) bus.Start = 1'b0;
        end
        check_val("t1_sb_empty", w_t'(exp_q.size()), w_t'(0));
        check_val("t1_ce1_total", w_t'(ce1_cnt - c0), w_t'(4));

        // Backpressure: OutReady low in cycles 2..6
        c0 = ce1_cnt;
        n2 = 0;
        start_cmd(3, 4, 1'b1);
        for (int c = 0; c <= 7; c++) begin
            bus.OutReady = !(c >= 2 && c <= 6);
            @(negedge clk);
            if (bus.ce1 && c <= 6) n2++;
            if (c == 4) check_val("t2_held", bus.OutData, mem[3]);
            tick();
            if (c == 0) bus.Start = 1'b0;
        end
        check_val("t2_ce1_stall", w_t'(n2), w_t'(2));
        bus.OutReady = 1'b1;
        wait_done("t2_done_seen", 30, e);
        check_val("t2_err", w_t'(e), w_t'(0));
        tick();
        check_val("t2_sb_empty", w_t'(exp_q.size()), w_t'(0));
        check_val("t2_ce1_total", w_t'(ce1_cnt - c0), w_t'(4));

        // Zero-length command
        c0 = ce1_cnt;
        start_cmd(0, 0, 1'b0);
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            check_val("t3_ce1", w_t'(bus.ce1), w_t'(0));
            check_val("t3_busy", w_t'(bus.Busy), w_t'(0));
            check_val("t3_done", w_t'(bus.Done), w_t'(c == 1));
            check_val("t3_err", w_t'(bus.Err), w_t'(0));
            tick();
            if (c == 0) bus.Start = 1'b0;
        end
        check_val("t3_ce1_total", w_t'(ce1_cnt - c0), w_t'(0));

        // Command ending exactly at the top of the RAM is legal
        start_cmd(12, 4, 1'b1);
        tick();
        bus.Start = 1'b0;
        wait_done("t4a_done_seen", 30, e);
        check_val("t4a_err", w_t'(e), w_t'(0));
        tick();
        check_val("t4a_sb_empty", w_t'(exp_q.size()), w_t'(0));

        // Command crossing the top of the RAM
        c0 = ce1_cnt;
`ifdef RAMRD_WRAP_EN
        start_cmd(14, 4, 1'b1);
        tick();
        bus.Start = 1'b0;
        wait_done("t4_done_seen", 30, e);
        check_val("t4_err", w_t'(e), w_t'(0));
        tick();
        check_val("t4_sb_empty", w_t'(exp_q.size()), w_t'(0));
        check_val("t4_ce1_total", w_t'(ce1_cnt - c0), w_t'(4));
`else
        start_cmd(14, 4, 1'b0);
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            check_val("t4_ce1", w_t'(bus.ce1), w_t'(0));
            check_val("t4_busy", w_t'(bus.Busy), w_t'(0));
            check_val("t4_done", w_t'(bus.Done), w_t'(c == 1));
            check_val("t4_err", w_t'(bus.Err), w_t'(c == 1));
            tick();
            if (c == 0) bus.Start = 1'b0;
        end
        check_val("t4_ce1_total", w_t'(ce1_cnt - c0), w_t'(0));
`endif

        // Reset in cycle 3 of a Len=8 command
        start_cmd(5, 8, 1'b1);
        tick();
        bus.Start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        check_val("t5_valid", w_t'(bus.OutValid), w_t'(0));
        check_val("t5_ce1", w_t'(bus.ce1), w_t'(0));
        check_val("t5_busy", w_t'(bus.Busy), w_t'(0));
        exp_q.delete();
        tick();
        tick();
        reset = 1'b0;
        tick();
        w0 = word_cnt;
        start_cmd(0, 2, 1'b1);
        tick();
        bus.Start = 1'b0;
        wait_done("t5_done_seen", 30, e);
        check_val("t5_err", w_t'(e), w_t'(0));
        tick();
        tick();
        check_val("t5_sb_empty", w_t'(exp_q.size()), w_t'(0));
        check_val("t5_words", w_t'(word_cnt - w0), w_t'(2));

        // Start while busy is ignored
        c0 = ce1_cnt;
        w0 = word_cnt;
        start_cmd(8, 5, 1'b1);
        tick();
        bus.Start = 1'b0;
        tick();
        start_cmd(0, 3, 1'b0);
        tick();
        bus.Start = 1'b0;
        wait_done("t6_done_seen", 30, e);
        check_val("t6_err", w_t'(e), w_t'(0));
        repeat (5) tick();
        check_val("t6_busy", w_t'(bus.Busy), w_t'(0));
        check_val("t6_sb_empty", w_t'(exp_q.size()), w_t'(0));
        check_val("t6_ce1_total", w_t'(ce1_cnt - c0), w_t'(5));
        check_val("t6_words", w_t'(word_cnt - w0), w_t'(5));

        // Random backpressure over a longer block
        w0 = word_cnt;
        start_cmd(2, 10, 1'b1);
        tick();
        bus.Start = 1'b0;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 200 && !seen; i++) begin
                bus.OutReady = 1'($urandom_range(0, 1));
                @(negedge clk);
                if (bus.Done) seen = 1'b1;
                tick();
            end
            check_val("t7_done_seen", w_t'(seen), w_t'(1));
        end
        bus.OutReady = 1'b1;
        tick();
        check_val("t7_sb_empty", w_t'(exp_q.size()), w_t'(0));
        check_val("t7_words", w_t'(word_cnt - w0), w_t'(10));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_ram1r_stream_reader
